pll_reset_seq: RTL
==================

Name: pll_reset_seq

Overview:
- Upstream control stage for the PLLE2 feature test: turns raw board switches into clean PLL reset/power-down controls and supervises lock.
- Synchronises and debounces `sw` inputs, issues minimum-width PLL reset pulses, retries on lock timeout, and flags success or failure.
- Its `pll_rst`/`pll_pwrdwn` outputs drive the PLL test block's RST/I_PWRDWN inputs; that block's LOCKED output returns as `pll_locked`.

Parameters:
- DEBOUNCE_CYCLES, 65536: consecutive stable cycles required before a debounced switch changes.
- RST_PULSE_CYCLES, 16: cycles `pll_rst` is held high per reset attempt; minimum 1.
- LOCK_TIMEOUT, 4096: cycles allowed in WAIT_LOCK before the attempt is declared failed.
- MAX_RETRIES, 3: extra reset attempts after the first before entering FAIL.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous, active-low reset.
- sw_rst  input  1  raw switch, asynchronous; user reset request.
- sw_pwrdwn  input  1  raw switch, asynchronous; user power-down request.
- pll_locked  input  1  PLL LOCKED, asynchronous to clk.
- pll_rst  output  1  PLL reset, active high.
- pll_pwrdwn  output  1  PLL power-down, active high.
- ready  output  1  PLL locked and stable.
- fail  output  1  retries exhausted.
- retry_cnt  output  $clog2(MAX_RETRIES+1)  attempts consumed since the last clean start.

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-low on `rst_n`.
- Input conditioning:
  - All three inputs pass through 2-flop synchronisers.
  - `sw_rst` and `sw_pwrdwn` are debounced by independent counters. The debounced value updates only after the synced input differs from it for DEBOUNCE_CYCLES consecutive cycles. The counter clears on any cycle the input matches.
  - `pll_locked` is synchronised only, not debounced.
  - Raw-to-FSM latency: 2 sync + DEBOUNCE_CYCLES + 1 register.
- Reset values: state=RESET, pll_rst=1, pll_pwrdwn=0, ready=0, fail=0, retry_cnt=0. Debounced values=0, all counters=0.
- All outputs are registered, decoded from state on the next edge.
- FSM states and outputs:
  - PWRDN: pll_pwrdwn=1, pll_rst=1, ready=0.
  - RESET: pll_rst=1; pulse counter runs.
  - WAIT_LOCK: pll_rst=0; timeout counter runs.
  - LOCKED: ready=1.
  - FAIL: fail=1, pll_rst=1.
- Transitions, in priority order:
  1. Debounced pwrdwn=1 in any state -> PWRDN.
  2. PWRDN with debounced pwrdwn=0 -> RESET, retry_cnt=0.
  3. Rising edge of debounced sw_rst in any non-PWRDN state -> RESET, retry_cnt=0, pulse counter restarts.
  4. RESET, after RST_PULSE_CYCLES cycles -> WAIT_LOCK, timer=0.
  5. WAIT_LOCK with synced locked=1 -> LOCKED.
  6. WAIT_LOCK with timer=LOCK_TIMEOUT-1 and no lock: if retry_cnt<MAX_RETRIES, retry_cnt+1 and go to RESET; else go to FAIL.
  7. LOCKED with synced locked=0 (loss of lock) -> RESET, retry_cnt=0.
  8. FAIL is held until rule 1 or rule 3 applies.
- Simultaneous events:
  - Lock and timeout in the same cycle: lock wins.
  - Sw_rst edge and pwrdwn in the same cycle: PWRDN wins.
- Counters:
  - Saturate; they never wrap.
  - retry_cnt never exceeds MAX_RETRIES.
  - Widths are set by $clog2 of (parameter+1).
- Mid-operation behaviour:
  - rst_n low in any state returns everything to reset values on the next edge.
  - A lock glitch during RESET is ignored.
- pll_rst is never low for fewer than 1 cycle between pulses: RESET -> WAIT_LOCK always spends at least one cycle deasserted.

Decomposition:
- Package `pll_seq_pkg`: state enum (PWRDN, RESET, WAIT_LOCK, LOCKED, FAIL) and the synchroniser depth constant (2).
- One natural sub-module, `sw_debounce` (sync + debounce for one bit, parameter DEBOUNCE_CYCLES), instantiated twice.
- Lock synchroniser and FSM live in the top.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, RST_PULSE_CYCLES=8, LOCK_TIMEOUT=32, MAX_RETRIES=2.
- Reset release with `pll_locked` tied to 1 at cycle 20 -> pll_rst high exactly 8 cycles after rst_n rises; ready=1 within 3 cycles of the sync'd lock; retry_cnt=0.
- `pll_locked` held 0 -> three attempts of 8 pulse + 32 wait cycles; retry_cnt reaches 2; then fail=1, pll_rst=1, ready=0.
- From FAIL, `sw_rst` high for 10 cycles -> after 2+4+1 cycles state is RESET, fail=0, retry_cnt=0; with lock now 1, ready=1.
- `sw_pwrdwn` bounce (toggling every 2 cycles for 20 cycles) -> no change on pll_pwrdwn. A steady high then asserts pll_pwrdwn=1 and pll_rst=1 7 cycles later. Release -> 8-cycle reset pulse.
- In LOCKED, `pll_locked` drops for 1 cycle -> ready=0, new 8-cycle reset pulse, retry_cnt=0.
- `rst_n` low for 1 cycle during WAIT_LOCK with retry_cnt=1 -> all outputs at reset values on the next edge; retry_cnt=0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding and synchroniser depth.
package pll_seq_pkg;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    PWRDN,
    RESET,
    WAIT_LOCK,
    LOCKED,
    FAIL
  } state_t;
endpackage

// File: rtl/sw_debounce.sv
// One-bit switch conditioner: 2-flop synchroniser followed by a stability counter.
module sw_debounce
  import pll_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      // Any agreeing cycle restarts the stability window.
      if (sync[SYNC_STAGES-1] == dout) begin
        cnt <= '0;
      end else if (cnt >= CMAX) begin
        dout <= sync[SYNC_STAGES-1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset/power-down sequencer: conditions switches, pulses reset, retries on lock timeout.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 65536,
  parameter int RST_PULSE_CYCLES = 16,
  parameter int LOCK_TIMEOUT     = 4096,
  parameter int MAX_RETRIES      = 3
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               sw_rst,
  input  logic                               sw_pwrdwn,
  input  logic                               pll_locked,
  output logic                               pll_rst,
  output logic                               pll_pwrdwn,
  output logic                               ready,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);
  localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [PW-1:0] PMAX = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRIES);

  logic rst_db, pwr_db, rst_db_q, rst_rise, lock_s;
  logic [SYNC_STAGES-1:0] lock_sync;

  state_t        state, nxt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [RW-1:0] rc_nxt;

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk(clk), .rst_n(rst_n), .din(sw_rst), .dout(rst_db)
  );

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pwr (
    .clk(clk), .rst_n(rst_n), .din(sw_pwrdwn), .dout(pwr_db)
  );

  assign lock_s   = lock_sync[SYNC_STAGES-1];
  assign rst_rise = rst_db & ~rst_db_q;

  // Power-down outranks everything, then a user reset edge, then per-state progress.
  always_comb begin
    nxt      = state;
    pcnt_nxt = pcnt;
    tmr_nxt  = tmr;
    rc_nxt   = retry_cnt;
    if (pwr_db) begin
      nxt = PWRDN;
    end else if (state == PWRDN || rst_rise) begin
      nxt      = RESET;
      rc_nxt   = '0;
      pcnt_nxt = '0;
    end else begin
      case (state)
        RESET: begin
          if (pcnt >= PMAX) begin
            nxt     = WAIT_LOCK;
            tmr_nxt = '0;
          end else begin
            pcnt_nxt = pcnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            nxt = LOCKED;
          end else if (tmr >= TMAX) begin
            if (retry_cnt < RMAX) begin
              rc_nxt   = retry_cnt + 1'b1;
              nxt      = RESET;
              pcnt_nxt = '0;
            end else begin
              nxt = FAIL;
            end
          end else begin
            tmr_nxt = tmr + 1'b1;
          end
        end
        LOCKED: begin
          if (!lock_s) begin
            nxt      = RESET;
            rc_nxt   = '0;
            pcnt_nxt = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RESET;
      pcnt       <= '0;
      tmr        <= '0;
      retry_cnt  <= '0;
      lock_sync  <= '0;
      rst_db_q   <= 1'b0;
      pll_rst    <= 1'b1;
      pll_pwrdwn <= 1'b0;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state      <= nxt;
      pcnt       <= pcnt_nxt;
      tmr        <= tmr_nxt;
      retry_cnt  <= rc_nxt;
      lock_sync  <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
      rst_db_q   <= rst_db;
      pll_rst    <= (nxt == PWRDN) || (nxt == RESET) || (nxt == FAIL);
      pll_pwrdwn <= (nxt == PWRDN);
      ready      <= (nxt == LOCKED);
      fail       <= (nxt == FAIL);
    end
  end
endmodule
